// File: rtl/score_digits_render_pkg.sv
// Shared constants for the score digit renderer: cell geometry, segment
// indices, segment bounding spans and the conversion request FSM states.
package score_digits_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned CELL_W     = 16;
  localparam int unsigned CELL_H     = 24;
  localparam int unsigned PITCH      = 20;
  localparam int unsigned T          = 3;

  // Bit positions inside a 7-bit segment mask
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Column spans (local x) for left bar, horizontal bars and right bar
  localparam int unsigned COL_L_LO = 0;
  localparam int unsigned COL_L_HI = T - 1;
  localparam int unsigned COL_M_LO = T;
  localparam int unsigned COL_M_HI = CELL_W - T - 1;
  localparam int unsigned COL_R_LO = CELL_W - T;
  localparam int unsigned COL_R_HI = CELL_W - 1;

  // Row spans (local y) for top bar, upper verticals, middle bar,
  // lower verticals and bottom bar
  localparam int unsigned ROW_T_LO = 0;
  localparam int unsigned ROW_T_HI = T - 1;
  localparam int unsigned ROW_U_LO = T;
  localparam int unsigned ROW_U_HI = CELL_H / 2 - 2;
  localparam int unsigned ROW_M_LO = CELL_H / 2 - 1;
  localparam int unsigned ROW_M_HI = CELL_H / 2;
  localparam int unsigned ROW_L_LO = CELL_H / 2 + 1;
  localparam int unsigned ROW_L_HI = CELL_H - T - 1;
  localparam int unsigned ROW_B_LO = CELL_H - T;
  localparam int unsigned ROW_B_HI = CELL_H - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_WAIT
  } req_state_t;

  // Inclusive range test done as one unsigned subtract so a value below lo
  // wraps high and fails, avoiding constant-folded compares against zero.
  function automatic logic in_span(input logic [9:0] v,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (10'(v - lo) <= 10'(hi - lo));
  endfunction

endpackage

// File: rtl/score_digits_render_if.sv
// Pixel timing, converter handshake and pixel output bundle for the score
// digit renderer. master = renderer side, slave = raster/converter side.
interface score_digits_render_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic [3:0] dig_5;
  logic [3:0] dig_4;
  logic [3:0] dig_3;
  logic [3:0] dig_2;
  logic [3:0] dig_1;
  logic       ready;
  logic       load;
  logic [5:0] rgb;

  modport master (
    input  hcount, vcount, active,
    input  dig_5, dig_4, dig_3, dig_2, dig_1, ready,
    output load, rgb
  );

  modport slave (
    output hcount, vcount, active,
    output dig_5, dig_4, dig_3, dig_2, dig_1, ready,
    input  load, rgb
  );
endinterface

// File: rtl/score_digits_render_seg7_decode.sv
// BCD to seven-segment mask decoder, purely combinational. Mask bit order
// follows SEG_A (bit 0) .. SEG_G (bit 6). Values 10-15 light nothing.
module seg7_decode
  import score_digits_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Standard glyph table, bits are {g,f,e,d,c,b,a}
  always_comb begin
    o_seg = '0;
    case (i_bcd)
      4'd0: o_seg = 7'h3F;
      4'd1: o_seg = 7'h06;
      4'd2: o_seg = 7'h5B;
      4'd3: o_seg = 7'h4F;
      4'd4: o_seg = 7'h66;
      4'd5: o_seg = 7'h6D;
      4'd6: o_seg = 7'h7D;
      4'd7: o_seg = 7'h07;
      4'd8: o_seg = 7'h7F;
      4'd9: o_seg = 7'h6F;
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/score_digits_render.sv
// Five-digit seven-segment score overlay on the 6-bit VGA raster.
// Requests one BCD conversion per frame at the start of vertical blanking,
// captures the result into shadow registers, and renders from the shadow
// copy through a 2-stage pixel pipeline.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (the least significant digit is always drawn).
module score_digits_render
  import score_digits_pkg::*;
#(
  parameter logic [9:0] X0     = 10'd8,
  parameter logic [9:0] Y0     = 10'd8,
  parameter logic [9:0] V_TRIG = 10'd480,
  parameter logic [5:0] FG     = 6'b111111,
  parameter logic [5:0] BG     = 6'b000000
) (
  input  logic                        clk,
  input  logic                        reset,
  score_digits_render_if.master       bus
);

  // ---------------------------------------------------------------------
  // Conversion request FSM and shadow registers
  // ---------------------------------------------------------------------
  req_state_t       r_state;
  req_state_t       w_state_nxt;
  logic             w_load_nxt;
  logic             w_capture;
  logic             w_trig;
  logic             r_load;
  logic [4:0][3:0]  r_shadow;   // [0] = s5 (cell 0) .. [4] = s1 (cell 4)

  assign w_trig = (bus.hcount == 10'd0) && (bus.vcount == V_TRIG) && bus.ready;

  // Next-state, load request and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_state_nxt = ST_LOAD;
          w_load_nxt  = 1'b1;
        end
      end
      ST_LOAD:   w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; load is registered so it is high exactly while in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Shadow digits change only when the converter reports done in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow <= {bus.dig_1, bus.dig_2, bus.dig_3, bus.dig_4, bus.dig_5};
    end
  end

  assign bus.load = r_load;

  // ---------------------------------------------------------------------
  // Stage 1: locate pixel within the digit row
  // ---------------------------------------------------------------------
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_x_ok;
  logic       w_y_ok;
  logic       w_hit_cell;
  logic [2:0] w_cell;
  logic [9:0] w_lx;

  logic       r_act;
  logic       r_in_cell;
  logic [2:0] r_cell;
  logic [9:0] r_lx;
  logic [9:0] r_ly;

  assign w_dx   = bus.hcount - X0;
  assign w_dy   = bus.vcount - Y0;
  assign w_x_ok = (bus.hcount >= X0);
  assign w_y_ok = (bus.vcount >= Y0) && (w_dy < 10'(CELL_H));

  // Cell search by offset compare; the 4 gap columns of each pitch match no cell
  always_comb begin
    w_hit_cell = 1'b0;
    w_cell     = '0;
    w_lx       = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (10'(w_dx - 10'(PITCH * k)) < 10'(CELL_W)) begin
        w_hit_cell = 1'b1;
        w_cell     = 3'(k);
        w_lx       = 10'(w_dx - 10'(PITCH * k));
      end
    end
  end

  // Stage 1 pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act     <= 1'b0;
      r_in_cell <= 1'b0;
      r_cell    <= '0;
      r_lx      <= '0;
      r_ly      <= '0;
    end else begin
      r_act     <= bus.active;
      r_in_cell <= w_x_ok && w_y_ok && w_hit_cell;
      r_cell    <= w_cell;
      r_lx      <= w_lx;
      r_ly      <= w_dy;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: digit select, segment hit, colour mux
  // ---------------------------------------------------------------------
  logic [3:0] w_digit;
  logic       w_blank;
  logic [6:0] w_seg;
  logic [6:0] w_seg_in;
  logic       w_hit;
`ifdef LEADING_ZERO_BLANK_EN
  logic       w_lead;
`endif

  // Pick the shadow digit for this cell and decide leading-zero blanking
  always_comb begin
    w_digit = '0;
    w_blank = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_cell == 3'(k)) w_digit = r_shadow[k];
    end
`ifdef LEADING_ZERO_BLANK_EN
    // w_lead accumulates "this digit and all more-significant ones are 0"
    w_lead = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      w_lead = w_lead & (r_shadow[k] == 4'd0);
      if (r_cell == 3'(k)) w_blank = w_lead;
    end
`endif
  end

  seg7_decode u_seg7_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Which segment rectangles contain the local pixel
  always_comb begin
    w_seg_in        = '0;
    w_seg_in[SEG_A] = in_span(r_lx, 10'(COL_M_LO), 10'(COL_M_HI)) &&
                      in_span(r_ly, 10'(ROW_T_LO), 10'(ROW_T_HI));
    w_seg_in[SEG_B] = in_span(r_lx, 10'(COL_R_LO), 10'(COL_R_HI)) &&
                      in_span(r_ly, 10'(ROW_U_LO), 10'(ROW_U_HI));
    w_seg_in[SEG_C] = in_span(r_lx, 10'(COL_R_LO), 10'(COL_R_HI)) &&
                      in_span(r_ly, 10'(ROW_L_LO), 10'(ROW_L_HI));
    w_seg_in[SEG_D] = in_span(r_lx, 10'(COL_M_LO), 10'(COL_M_HI)) &&
                      in_span(r_ly, 10'(ROW_B_LO), 10'(ROW_B_HI));
    w_seg_in[SEG_E] = in_span(r_lx, 10'(COL_L_LO), 10'(COL_L_HI)) &&
                      in_span(r_ly, 10'(ROW_L_LO), 10'(ROW_L_HI));
    w_seg_in[SEG_F] = in_span(r_lx, 10'(COL_L_LO), 10'(COL_L_HI)) &&
                      in_span(r_ly, 10'(ROW_U_LO), 10'(ROW_U_HI));
    w_seg_in[SEG_G] = in_span(r_lx, 10'(COL_M_LO), 10'(COL_M_HI)) &&
                      in_span(r_ly, 10'(ROW_M_LO), 10'(ROW_M_HI));
  end

  assign w_hit = r_in_cell && !w_blank && (|(w_seg & w_seg_in));

  logic [5:0] r_rgb;

  // Stage 2 colour register: black outside the active area
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
    end else if (!r_act) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_hit ? FG : BG;
    end
  end

  assign bus.rgb = r_rgb;

endmodule

// File: tb/tb_score_digits_render.sv
module tb_score_digits_render;

  localparam logic [5:0] FG = 6'h3F;
  localparam logic [5:0] BG = 6'h00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_digits_render_if bus ();

  score_digits_render u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit lzb;
  int exp_sh [5];   // expected shadow: [0] = most significant digit

  string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit in_seg(input byte c, input int lx, input int ly);
    case (c)
      "a": return lx >= 3  && lx <= 12 && ly >= 0  && ly <= 2;
      "b": return lx >= 13 && lx <= 15 && ly >= 3  && ly <= 10;
      "c": return lx >= 13 && lx <= 15 && ly >= 13 && ly <= 20;
      "d": return lx >= 3  && lx <= 12 && ly >= 21 && ly <= 23;
      "e": return lx >= 0  && lx <= 2  && ly >= 13 && ly <= 20;
      "f": return lx >= 0  && lx <= 2  && ly >= 3  && ly <= 10;
      "g": return lx >= 3  && lx <= 12 && ly >= 11 && ly <= 12;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_blank(input int k);
    if (!lzb || k == 4) return 1'b0;
    for (int j = 0; j <= k; j++) if (exp_sh[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [5:0] model_px(input int h, input int v, input bit a);
    int dx, dy, k, lx;
    string s;
    if (!a) return 6'd0;
    if (h < 8 || v < 8) return BG;
    dx = h - 8;
    dy = v - 8;
    if (dx >= 100 || dy >= 24) return BG;
    k  = dx / 20;
    lx = dx % 20;
    if (lx >= 16) return BG;
    if (is_blank(k)) return BG;
    if (exp_sh[k] > 9) return BG;
    s = SEGS[exp_sh[k]];
    for (int i = 0; i < s.len(); i++) if (in_seg(s[i], lx, dy)) return FG;
    return BG;
  endfunction

  // ---- streaming pixel driver: one pixel per clock, compared 2 clocks later ----
  logic [5:0] p_exp [2];
  bit         p_val [2];
  int         sw_err;
  int         bad_h, bad_v;
  logic [5:0] bad_got, bad_exp;
  int         p_h [2];
  int         p_v [2];

  task automatic px(input int h, input int v, input bit a);
    @(posedge clk); #1;
    if (p_val[1] && bus.rgb !== p_exp[1]) begin
      if (sw_err == 0) begin
        bad_h = p_h[1]; bad_v = p_v[1]; bad_got = bus.rgb; bad_exp = p_exp[1];
      end
      sw_err++;
    end
    p_exp[1] = p_exp[0]; p_val[1] = p_val[0]; p_h[1] = p_h[0]; p_v[1] = p_v[0];
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    bus.active = a;
    p_exp[0] = model_px(h, v, a);
    p_val[0] = 1'b1;
    p_h[0] = h; p_v[0] = v;
  endtask

  task automatic stream_begin();
    sw_err = 0;
    p_val[0] = 1'b0;
    p_val[1] = 1'b0;
  endtask

  task automatic stream_end(input string name);
    px(1, 0, 1'b0);
    px(1, 0, 1'b0);
    if (sw_err != 0)
      $display("  first bad pixel h=%0d v=%0d got %h exp %h", bad_h, bad_v, bad_got, bad_exp);
    chk(name, sw_err, 0);
  endtask

  task automatic sweep(input string name, input int h0, input int h1, input int v0, input int v1);
    stream_begin();
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        px(h, v, 1'b1);
    stream_end(name);
  endtask

  task automatic rnd(input string name, input int n);
    stream_begin();
    repeat (n) px(int'($urandom_range(127, 0)), int'($urandom_range(40, 0)),
                  $urandom_range(9, 0) != 0);
    stream_end(name);
  endtask

  // ---- single pixel with inputs held over the pipeline ----
  task automatic hold_chk(input string name, input int h, input int v, input bit a,
                          input logic [5:0] exp);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    bus.active = a;
    @(posedge clk); @(posedge clk); #1;
    chk(name, bus.rgb, exp);
  endtask

  task automatic set_digs(input int d5, input int d4, input int d3, input int d2, input int d1);
    bus.dig_5 = 4'(d5); bus.dig_4 = 4'(d4); bus.dig_3 = 4'(d3);
    bus.dig_2 = 4'(d2); bus.dig_1 = 4'(d1);
  endtask

  // Full request: trigger, load pulse, converter busy ~50 cycles, then result
  task automatic request(input int d5, input int d4, input int d3, input int d2, input int d1);
    int hi;
    bus.hcount = 10'd0; bus.vcount = 10'd480; bus.active = 1'b0; bus.ready = 1'b1;
    set_digs(8, 8, 8, 8, 8);
    @(posedge clk); #1;
    chk("load_pulse", bus.load, 1);
    bus.hcount = 10'd1;
    @(posedge clk); #1;
    chk("load_drop", bus.load, 0);
    // converter still shows ready (with stale digits) for one more cycle
    @(posedge clk); #1;
    bus.ready = 1'b0;
    hi = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.load) hi++;
    end
    chk("load_quiet", hi, 0);
    set_digs(d5, d4, d3, d2, d1);
    bus.ready = 1'b1;
    @(posedge clk); #1;
    exp_sh = '{d5, d4, d3, d2, d1};
    set_digs(8, 8, 8, 8, 8);
  endtask

  typedef struct {
    string      name;
    int         h;
    int         v;
    bit         a;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    exp_sh = '{0, 0, 0, 0, 0};
    reset = 1'b1;
    bus.hcount = 10'd1; bus.vcount = 10'd0; bus.active = 1'b1; bus.ready = 1'b1;
    set_digs(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_load", bus.load, 0);
    chk("reset_rgb", bus.rgb, 0);
    reset = 1'b0;

    // Shadow at reset value 0: targeted pixels
    tbl[0]  = '{"c4_seg_a",    96,  9, 1'b1, FG};
    tbl[1]  = '{"c0_corner",    8,  9, 1'b1, BG};
    tbl[2]  = '{"inactive",    96,  9, 1'b0, 6'd0};
    tbl[3]  = '{"c4_seg_f",    88, 15, 1'b1, FG};
    tbl[4]  = '{"c4_seg_g_off",96, 20, 1'b1, BG};
    tbl[5]  = '{"gap_col",    104,  9, 1'b1, BG};
    tbl[6]  = '{"left_of_x0",   5,  9, 1'b1, BG};
    tbl[7]  = '{"above_y0",    96,  5, 1'b1, BG};
    tbl[8]  = '{"far_right", 1023,  9, 1'b1, BG};
    tbl[9]  = '{"c4_seg_d",   100, 31, 1'b1, FG};
    tbl[10] = '{"c4_seg_c",   101, 28, 1'b1, FG};
    tbl[11] = '{"c4_corner",  103, 31, 1'b1, BG};
    tbl[12] = '{"c0_seg_a",    16,  9, 1'b1, lzb ? BG : FG};
    tbl[13] = '{"c3_seg_a",    71,  9, 1'b1, lzb ? BG : FG};
    for (int i = 0; i < 14; i++)
      hold_chk(tbl[i].name, tbl[i].h, tbl[i].v, tbl[i].a, tbl[i].exp);

    sweep("sweep_reset", 0, 119, 6, 33);

    // Trigger without ready: dropped, not queued
    bus.hcount = 10'd0; bus.vcount = 10'd480; bus.ready = 1'b0; bus.active = 1'b0;
    @(posedge clk); #1;
    chk("noready_load0", bus.load, 0);
    bus.hcount = 10'd1; bus.ready = 1'b1;
    @(posedge clk); #1;
    chk("noready_load1", bus.load, 0);
    @(posedge clk); #1;
    chk("noready_load2", bus.load, 0);

    request(1, 2, 3, 4, 5);
    sweep("sweep_12345", 0, 119, 6, 33);
    rnd("rand_12345", 400);

    request(0, 0, 4, 0, 7);
    hold_chk("lzb_c0_f", 8, 15, 1'b1, lzb ? BG : FG);
    hold_chk("lzb_c1_f", 28, 15, 1'b1, lzb ? BG : FG);
    hold_chk("inner_zero_f", 68, 15, 1'b1, FG);
    hold_chk("four_f", 48, 15, 1'b1, FG);
    sweep("sweep_00407", 0, 119, 6, 33);

    request(1, 2, 12, 3, 4);
    sweep("sweep_cell2_blank", 48, 63, 8, 31);
    sweep("sweep_12c34", 0, 119, 6, 33);

    // Reset while waiting for the converter
    bus.hcount = 10'd0; bus.vcount = 10'd480; bus.ready = 1'b1; bus.active = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_load", bus.load, 1);
    bus.hcount = 10'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_load0", bus.load, 0);
    chk("rst_wait_rgb0", bus.rgb, 0);
    reset = 1'b0;
    exp_sh = '{0, 0, 0, 0, 0};
    set_digs(9, 9, 9, 9, 9);
    bus.hcount = 10'd5; bus.vcount = 10'd3; bus.ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_wait_noload", bus.load, 0);
    sweep("sweep_after_rst", 0, 119, 6, 33);

    // FSM is back in IDLE: a fresh request is honoured
    request(9, 8, 7, 6, 5);
    rnd("rand_98765", 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_digits_render.md
# score_digits_render

Consumes the five BCD digits produced by the binary-to-BCD converter and draws them as scaled seven-segment glyphs on the 6-bit VGA raster. It issues one conversion request per frame during vertical blanking. It latches the resulting digits into shadow registers so a frame never shows a partially updated value. It outputs a pipelined 6-bit RRGGBB pixel for the VGA output stage.

## Interface
- X0, 10'd8: left pixel column of the most-significant digit cell
- Y0, 10'd8: top pixel row of the digit cells
- V_TRIG, 10'd480: vcount value on which a conversion is requested (first blanking line)
- FG, 6'b111111: RRGGBB colour of lit segments
- BG, 6'b000000: RRGGBB colour inside the active area where no segment is lit
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- active  in  1  high when (hcount, vcount) is in the visible area
- dig_5..dig_1  in  4 each  BCD digits from the converter, dig_5 most significant
- ready  in  1  converter idle / digits valid
- load  out  1  one-cycle conversion request to the converter
- rgb  out  6  pixel colour, 2 bits each R, G, B

## Operation
- Request FSM states: IDLE, LOAD, SETTLE, WAIT.
- IDLE -> LOAD: only when hcount==0 and vcount==V_TRIG and ready==1. Otherwise the trigger is dropped; no request is queued.
- LOAD: load=1 for exactly this cycle; next state SETTLE.
- SETTLE: one cycle; ready is ignored, because the converter drops ready one cycle after load. Next state WAIT.
- WAIT: on ready==1, copy dig_5..dig_1 into shadow registers s5..s1 in the same cycle and return to IDLE.
- A trigger while not IDLE is ignored.
- Shadow registers change only in WAIT. Rendering always uses the shadow registers.
- Digit cell geometry:
  - each cell is 16x24 px; pitch is 20 px
  - cell k (k=0 for s5 .. k=4 for s1) spans x in [X0+20k, X0+20k+15] and y in [Y0, Y0+23]
  - columns 16..19 of each pitch are gap and are never lit
- Segments, in local coordinates (lx 0..15, ly 0..23), inclusive ranges:
  - a: lx 3..12, ly 0..2
  - b: lx 13..15, ly 3..10
  - c: lx 13..15, ly 13..20
  - d: lx 3..12, ly 21..23
  - e: lx 0..2, ly 13..20
  - f: lx 0..2, ly 3..10
  - g: lx 3..12, ly 11..12
- Standard 7-seg maps apply for 0-9; values 10-15 light no segment.
- Pixel colour selection:
  - rgb = FG if active and the pixel is inside a lit segment
  - rgb = BG if active otherwise
  - rgb = 6'b0 if not active
- Coordinate arithmetic is 10-bit unsigned. Pixels left of X0 or above Y0 are outside every cell, with no wrap-around.

## Timing
- Reset values: load=0, rgb=0, FSM=IDLE, s5..s1=0. With LZB enabled this displays a single "0".
- Reset mid-request returns the FSM to IDLE and keeps the shadow registers at 0.
- rgb latency is 2 cycles from hcount/vcount/active.
  - Stage 1 registers cell index, lx, ly, in-cell flag and active.
  - Stage 2 registers the segment hit and the colour mux.
- load is registered and asserted the cycle after the trigger condition is sampled.
- Shadow update happens in blanking, so the frame following the update shows the new value in full.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - shadow digit k (s5..s2) is rendered blank when it and all more-significant shadow digits are 0
  - s1 is always drawn
- Undefined: all five digits are always drawn, including leading zeros.

## Structure
- Shared package score_digits_pkg holds:
  - segment index constants (SEG_A..SEG_G)
  - CELL_W=16, CELL_H=24, PITCH=20, T=3
  - the FSM state enum
- Sub-module seg7_decode: 4-bit BCD in, 7-bit segment mask out; combinational; shared with other display blocks.

## Test plan
- Reset, then sweep one frame with X0=8, Y0=8 -> with LZB, only cell 4 (x 88..103) shows "0"; pixel (96,9) gives FG, pixel (8,9) gives BG.
- vcount=480, hcount=0, ready=1 -> load high for exactly 1 cycle, 1 cycle later. Converter model returns digits 1,2,3,4,5 after 50 cycles -> s5..s1 = 1,2,3,4,5 and the next frame renders "12345".
- Trigger with ready=0 -> no load pulse; FSM stays IDLE.
- Digits 0,0,4,0,7: with LZB the cells for s5 and s4 are blank; without LZB they show "0".
- Digit value 12 on s3 -> cell 2 is entirely BG.
- Reset asserted during WAIT -> load=0, FSM IDLE; the shadow is not updated even when ready rises later.
